// File: rtl/boot_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : boot_seq_ctrl
//  Brief    : Board bring-up sequencer (BIST -> RAM -> CONFIG -> LOAD).
//             Each stage is started with a one-cycle pulse and has a timeout.
//             A timed-out stage is retried a bounded number of times.
//  Revision : 1.0 - initial release
// ============================================================================
module boot_seq_ctrl #(
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        bist_done,
    input  logic        ram_done,
    input  logic        config_done,
    input  logic        load_done,
    output logic        bist_start,
    output logic        ram_start,
    output logic        config_start,
    output logic        load_start,
    output logic        busy,
    output logic        seq_done,
    output logic        error,
    output logic [1:0]  fail_stage,
    output logic [3:0]  retry_cnt,
    output logic [15:0] status_code,
    output logic        status_valid
);

    localparam int                 c_TMR_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]         c_MAX_RETRY = 4'(MAX_RETRY);
    localparam logic [15:0]        c_ST_IDLE   = 16'h0105;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIST = 3'd1,
        S_RAM  = 3'd2,
        S_CFG  = 3'd3,
        S_LOAD = 3'd4,
        S_DONE = 3'd5,
        S_FAIL = 3'd6
    } state_t;

    state_t              r_state,        w_state;
    logic [c_TMR_W-1:0]  r_timer,        w_timer;
    logic [3:0]          r_retry,        w_retry;
    logic [3:0]          r_start,        w_start;
    logic                r_busy,         w_busy;
    logic                r_seq_done,     w_seq_done;
    logic                r_error,        w_error;
    logic [1:0]          r_fail_stage,   w_fail_stage;
    logic [15:0]         r_status_code,  w_status_code;
    logic                r_status_valid, w_status_valid;

    logic [3:0]          w_done_vec;
    logic [1:0]          w_stg;
    logic                w_in_stage;
    logic                w_match;
    logic                w_expired;

    assign w_done_vec = {load_done, config_done, ram_done, bist_done};

    always_comb begin
        w_stg      = 2'd0;
        w_in_stage = 1'b1;
        case (r_state)
            S_BIST:  w_stg = 2'd0;
            S_RAM:   w_stg = 2'd1;
            S_CFG:   w_stg = 2'd2;
            S_LOAD:  w_stg = 2'd3;
            default: w_in_stage = 1'b0;
        endcase
    end

    assign w_match   = w_in_stage && w_done_vec[w_stg];
    assign w_expired = (r_timer == c_TMR_LAST);

    always_comb begin
        w_state        = r_state;
        w_timer        = r_timer;
        w_retry        = r_retry;
        w_start        = 4'b0000;
        w_busy         = r_busy;
        w_seq_done     = r_seq_done;
        w_error        = r_error;
        w_fail_stage   = r_fail_stage;
        w_status_code  = r_status_code;
        w_status_valid = 1'b0;

        if (abort) begin
            w_state        = S_IDLE;
            w_timer        = '0;
            w_retry        = 4'd0;
            w_busy         = 1'b0;
            w_seq_done     = 1'b0;
            w_error        = 1'b0;
            w_fail_stage   = 2'd0;
            w_status_code  = c_ST_IDLE;
            w_status_valid = (r_state != S_IDLE);
        end else if (!w_in_stage) begin
            if (start) begin
                w_state      = S_BIST;
                w_timer      = '0;
                w_retry      = 4'd0;
                w_start      = 4'b0001;
                w_busy       = 1'b1;
                w_seq_done   = 1'b0;
                w_error      = 1'b0;
                w_fail_stage = 2'd0;
            end
        end else if (w_match) begin
            // Done beats a coincident timeout.
            w_retry        = 4'd0;
            w_timer        = '0;
            w_status_valid = 1'b1;
            w_status_code  = 16'h010A | (16'h0010 << w_stg);
            if (r_state == S_LOAD) begin
                w_state    = S_DONE;
                w_busy     = 1'b0;
                w_seq_done = 1'b1;
            end else begin
                w_state = state_t'(r_state + 3'd1);
                w_start = 4'b0010 << w_stg;
            end
        end else if (w_expired) begin
            if (r_retry < c_MAX_RETRY) begin
                w_retry = r_retry + 4'd1;
                w_timer = '0;
                w_start = 4'b0001 << w_stg;
            end else begin
                w_state        = S_FAIL;
                w_timer        = '0;
                w_busy         = 1'b0;
                w_error        = 1'b1;
                w_fail_stage   = w_stg;
                w_status_valid = 1'b1;
                w_status_code  = 16'h0105 | (16'h0010 << w_stg);
            end
        end else begin
            w_timer = r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_retry        <= 4'd0;
            r_start        <= 4'b0000;
            r_busy         <= 1'b0;
            r_seq_done     <= 1'b0;
            r_error        <= 1'b0;
            r_fail_stage   <= 2'd0;
            r_status_code  <= c_ST_IDLE;
            r_status_valid <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_timer        <= w_timer;
            r_retry        <= w_retry;
            r_start        <= w_start;
            r_busy         <= w_busy;
            r_seq_done     <= w_seq_done;
            r_error        <= w_error;
            r_fail_stage   <= w_fail_stage;
            r_status_code  <= w_status_code;
            r_status_valid <= w_status_valid;
        end
    end

    assign bist_start   = r_start[0];
    assign ram_start    = r_start[1];
    assign config_start = r_start[2];
    assign load_start   = r_start[3];
    assign busy         = r_busy;
    assign seq_done     = r_seq_done;
    assign error        = r_error;
    assign fail_stage   = r_fail_stage;
    assign retry_cnt    = r_retry;
    assign status_code  = r_status_code;
    assign status_valid = r_status_valid;

endmodule
`default_nettype wire

// File: tb/tb_boot_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boot_seq_ctrl
//  Brief    : Self-checking bench for boot_seq_ctrl (vector table, directed
//             corner sequences, randomized traffic against a stage model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boot_seq_ctrl;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  done = 4'b0000;
    logic        bist_start, ram_start, config_start, load_start;
    logic        busy, seq_done, error, status_valid;
    logic [1:0]  fail_stage;
    logic [3:0]  retry_cnt;
    logic [15:0] status_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    boot_seq_ctrl #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .bist_done    (done[0]),
        .ram_done     (done[1]),
        .config_done  (done[2]),
        .load_done    (done[3]),
        .bist_start   (bist_start),
        .ram_start    (ram_start),
        .config_start (config_start),
        .load_start   (load_start),
        .busy         (busy),
        .seq_done     (seq_done),
        .error        (error),
        .fail_stage   (fail_stage),
        .retry_cnt    (retry_cnt),
        .status_code  (status_code),
        .status_valid (status_valid)
    );

    // Stage model: phase 0 idle, 1..4 = stage index + 1, 5 done, 6 fail.
    int          m_phase, m_age, m_tries, m_fail;
    logic [3:0]  m_pulse;
    logic [15:0] m_code;
    logic        m_sv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_tries = 0; m_fail = 0;
        m_pulse = 4'b0000; m_code = 16'h0105; m_sv = 1'b0;
    endtask

    task automatic model_enter(input int stg);
        m_phase = stg + 1;
        m_age   = 0;
        m_pulse = 4'b0001 << stg;
    endtask

    task automatic model_step(input logic s, input logic a, input logic [3:0] d);
        int stg;
        m_pulse = 4'b0000;
        m_sv    = 1'b0;
        if (a) begin
            m_sv    = (m_phase != 0);
            m_phase = 0; m_tries = 0; m_fail = 0; m_age = 0;
            m_code  = 16'h0105;
        end else if (m_phase == 0 || m_phase >= 5) begin
            if (s) begin
                model_enter(0);
                m_tries = 0;
                m_fail  = 0;
            end
        end else begin
            stg = m_phase - 1;
            if (d[stg]) begin
                m_code  = 16'h010A | (16'h0010 << stg);
                m_sv    = 1'b1;
                m_tries = 0;
                if (stg == 3) m_phase = 5;
                else          model_enter(stg + 1);
            end else if (m_age + 1 >= TIMEOUT) begin
                if (m_tries < MAX_RETRY) begin
                    m_tries++;
                    model_enter(stg);
                end else begin
                    m_phase = 6;
                    m_fail  = stg;
                    m_code  = 16'h0105 | (16'h0010 << stg);
                    m_sv    = 1'b1;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_model();
        check("busy",         32'(busy),         32'(m_phase >= 1 && m_phase <= 4));
        check("seq_done",     32'(seq_done),     32'(m_phase == 5));
        check("error",        32'(error),        32'(m_phase == 6));
        check("bist_start",   32'(bist_start),   32'(m_pulse[0]));
        check("ram_start",    32'(ram_start),    32'(m_pulse[1]));
        check("config_start", 32'(config_start), 32'(m_pulse[2]));
        check("load_start",   32'(load_start),   32'(m_pulse[3]));
        check("retry_cnt",    32'(retry_cnt),    32'(m_tries));
        check("status_code",  32'(status_code),  32'(m_code));
        check("status_valid", 32'(status_valid), 32'(m_sv));
        if (m_phase == 6) check("fail_stage", 32'(fail_stage), 32'(m_fail));
    endtask

    // Drive inputs just after an edge, clock once, compare #1 after the next edge.
    task automatic cycle(input logic s, input logic a, input logic [3:0] d);
        start = s; abort = a; done = d;
        @(posedge clk);
        model_step(s, a, d);
        #1;
        check_model();
        start = 1'b0; abort = 1'b0; done = 4'b0000;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'b0000);
    endtask

    typedef struct {
        logic        s;
        logic        a;
        logic [3:0]  d;
        logic        busy;
        logic        sd;
        logic        err;
        logic [3:0]  st;
        logic        sv;
        logic [15:0] code;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic a, input logic [3:0] d,
                                input logic b, input logic sd, input logic e,
                                input logic [3:0] st, input logic sv, input logic [15:0] code);
        vec_t v;
        v.s = s; v.a = a; v.d = d; v.busy = b; v.sd = sd; v.err = e;
        v.st = st; v.sv = sv; v.code = code;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        // start, abort, done | busy, seq_done, error, starts{L,C,R,B}, status_valid, status_code
        tbl[0]  = mk(1, 0, 4'b0000, 1, 0, 0, 4'b0001, 0, 16'h0105);
        tbl[1]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h0105);
        tbl[2]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h0105);
        tbl[3]  = mk(0, 0, 4'b0001, 1, 0, 0, 4'b0010, 1, 16'h011A);
        tbl[4]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h011A);
        tbl[5]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h011A);
        tbl[6]  = mk(0, 0, 4'b0010, 1, 0, 0, 4'b0100, 1, 16'h012A);
        tbl[7]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h012A);
        tbl[8]  = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h012A);
        tbl[9]  = mk(0, 0, 4'b0100, 1, 0, 0, 4'b1000, 1, 16'h014A);
        tbl[10] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h014A);
        tbl[11] = mk(0, 0, 4'b0000, 1, 0, 0, 4'b0000, 0, 16'h014A);
        tbl[12] = mk(0, 0, 4'b1000, 0, 1, 0, 4'b0000, 1, 16'h018A);
        tbl[13] = mk(0, 0, 4'b0000, 0, 1, 0, 4'b0000, 0, 16'h018A);
        tbl[14] = mk(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 1, 16'h0105);
        tbl[15] = mk(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 16'h0105);
        tbl[16] = mk(1, 0, 4'b0000, 1, 0, 0, 4'b0001, 0, 16'h0105);
        tbl[17] = mk(0, 0, 4'b1010, 1, 0, 0, 4'b0000, 0, 16'h0105);
        tbl[18] = mk(0, 0, 4'b0001, 1, 0, 0, 4'b0010, 1, 16'h011A);
        tbl[19] = mk(0, 1, 4'b0000, 0, 0, 0, 4'b0000, 1, 16'h0105);

        // Reset state, checked before any clock edge is released.
        model_reset();
        #12;
        check_model();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_model();

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].s, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d.busy", i),  32'(busy),         32'(tbl[i].busy));
            check($sformatf("tbl%0d.sdone", i), 32'(seq_done),     32'(tbl[i].sd));
            check($sformatf("tbl%0d.error", i), 32'(error),        32'(tbl[i].err));
            check($sformatf("tbl%0d.start", i),
                  32'({load_start, config_start, ram_start, bist_start}), 32'(tbl[i].st));
            check($sformatf("tbl%0d.sv", i),    32'(status_valid), 32'(tbl[i].sv));
            check($sformatf("tbl%0d.code", i),  32'(status_code),  32'(tbl[i].code));
        end

        // RAM never completes: one retry after 16 cycles, then FAIL.
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0001);
        check("ram_entry_pulse", 32'(ram_start), 32'd1);
        idle_cycles(TIMEOUT - 1);
        check("ram_no_early_retry", 32'(ram_start), 32'd0);
        cycle(1'b0, 1'b0, 4'b0000);
        check("ram_retry_pulse", 32'(ram_start), 32'd1);
        check("ram_retry_cnt",   32'(retry_cnt), 32'd1);
        check("ram_retry_nosv",  32'(status_valid), 32'd0);
        idle_cycles(TIMEOUT - 1);
        check("ram_still_busy", 32'(busy), 32'd1);
        cycle(1'b0, 1'b0, 4'b0000);
        check("ram_fail_error", 32'(error),        32'd1);
        check("ram_fail_stage", 32'(fail_stage),   32'd1);
        check("ram_fail_code",  32'(status_code),  32'h0125);
        check("ram_fail_sv",    32'(status_valid), 32'd1);
        check("ram_fail_busy",  32'(busy),         32'd0);
        cycle(1'b0, 1'b0, 4'b0000);
        check("fail_holds", 32'(error), 32'd1);

        // CONFIG done lands exactly on the first-attempt timeout edge.
        cycle(1'b1, 1'b0, 4'b0000);
        check("restart_retry", 32'(retry_cnt), 32'd0);
        check("restart_error", 32'(error),     32'd0);
        cycle(1'b0, 1'b0, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0010);
        idle_cycles(TIMEOUT - 1);
        cycle(1'b0, 1'b0, 4'b0100);
        check("cfg_edge_load_start", 32'(load_start),   32'd1);
        check("cfg_edge_no_retry",   32'(config_start), 32'd0);
        check("cfg_edge_code",       32'(status_code),  32'h014A);
        check("cfg_edge_retry_cnt",  32'(retry_cnt),    32'd0);

        // Abort from LOAD.
        cycle(1'b0, 1'b1, 4'b0000);
        check("abort_load_code", 32'(status_code),  32'h0105);
        check("abort_load_sv",   32'(status_valid), 32'd1);
        check("abort_load_busy", 32'(busy),         32'd0);

        // Asynchronous reset mid-CONFIG, after a retry has been used.
        cycle(1'b1, 1'b0, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0001);
        cycle(1'b0, 1'b0, 4'b0010);
        idle_cycles(TIMEOUT + 2);
        check("pre_rst_retry", 32'(retry_cnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_busy",  32'(busy),        32'd0);
        check("arst_retry", 32'(retry_cnt),   32'd0);
        check("arst_code",  32'(status_code), 32'h0105);
        check_model();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_model();
        cycle(1'b1, 1'b0, 4'b0000);
        check("post_rst_bist", 32'(bist_start), 32'd1);
        check("post_rst_retry", 32'(retry_cnt), 32'd0);

        // Randomized traffic against the stage model.
        for (int i = 0; i < 4000; i++) begin
            logic       s, a;
            logic [3:0] d;
            s = ($urandom % 20) == 0;
            a = ($urandom % 80) == 0;
            for (int b = 0; b < 4; b++) d[b] = ($urandom % 14) == 0;
            cycle(s, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boot_seq_ctrl.md
Name: boot_seq_ctrl

Overview:
- Sequences the board bring-up chain BIST -> RAM -> CONFIG -> LOAD.
- Issues a one-cycle start pulse to each stage, then waits for that stage's done flag from the flag decoder.
- Applies a per-stage timeout with bounded retries.
- Publishes a 16-bit status word, using the same code space as the flag decoder, for the Ethernet reporting path.

Parameters:
TIMEOUT, 1024, cycles allowed per attempt after a stage start pulse (min 2)
MAX_RETRY, 2, re-issues of a stage start after a timeout before declaring failure (0..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin sequence; sampled in IDLE, DONE, FAIL
abort  in  1  abandon sequence from any state
bist_done  in  1  BIST stage complete flag
ram_done  in  1  RAM stage complete flag
config_done  in  1  CONFIG stage complete flag
load_done  in  1  LOAD stage complete flag
bist_start  out  1  one-cycle stage request
ram_start  out  1  one-cycle stage request
config_start  out  1  one-cycle stage request
load_start  out  1  one-cycle stage request
busy  out  1  high in BIST/RAM/CFG/LOAD states
seq_done  out  1  level, high in DONE
error  out  1  level, high in FAIL
fail_stage  out  2  0=BIST 1=RAM 2=CFG 3=LOAD, valid while error=1
retry_cnt  out  4  retries used in current stage
status_code  out  16  last status word
status_valid  out  1  one-cycle pulse when status_code updates

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE; all *_start=0, busy=0, seq_done=0, error=0
  - fail_stage=0, retry_cnt=0, status_code=16'h0105, status_valid=0
  - internal timer=0
- States: IDLE, BIST, RAM, CFG, LOAD, DONE, FAIL.
- Stage entry:
  - start=1 at edge k while in IDLE/DONE/FAIL -> after edge k: state=BIST, bist_start=1 for exactly one cycle, busy=1, seq_done=0, error=0, timer=0, retry_cnt=0.
  - Entry into any stage state clears the timer and pulses that stage's start output for one cycle.
- In a stage, the timer increments each edge. Only the matching done flag is honoured; other done flags are ignored.
- Matching done at an edge -> advance to the next stage:
  - retry_cnt=0
  - status_valid=1 with status_code: BIST 16'h011A, RAM 16'h012A, CFG 16'h014A, LOAD 16'h018A
  - LOAD done -> DONE, seq_done=1, busy=0
- Timeout: timer==TIMEOUT-1 at an edge with no matching done.
  - If retry_cnt<MAX_RETRY: retry_cnt+1, timer=0, re-pulse the same start output; no status pulse.
  - Otherwise -> FAIL: error=1, busy=0, fail_stage set, status_valid=1 with status_code BIST 16'h0115, RAM 16'h0125, CFG 16'h0145, LOAD 16'h0185.
- Done and timeout on the same edge: done wins.
- A done flag in the same cycle as its own start pulse is accepted.
- abort=1 at any edge (highest priority after reset):
  - state=IDLE; start outputs and flags cleared; retry_cnt=0
  - status_code=16'h0105; status_valid=1 only if the state was not already IDLE
- start while busy is ignored.
- start and abort on the same edge: abort wins.
- DONE and FAIL hold until start (restart at BIST) or abort (to IDLE).
- rst asserted mid-sequence returns immediately to reset values. No start pulse is issued on rst deassertion.
- The timer is sized clog2(TIMEOUT) bits and never wraps. The timeout compare occurs before overflow.

Test Plan:
- TIMEOUT=16, MAX_RETRY=1. Pulse start, then return each done 3 cycles after its start pulse -> four status pulses 011A, 012A, 014A, 018A in order; seq_done=1; busy=0; error=0.
- Withhold ram_done -> ram_start pulses at entry and again 16 cycles later; retry_cnt=1; after 16 more cycles FAIL with error=1, fail_stage=1, status_code=0125.
- In CFG, assert config_done on the exact timeout edge of the first attempt -> advance to LOAD, status 014A, no retry.
- In BIST, pulse ram_done and load_done -> ignored, state stays BIST; then bist_done -> RAM, status 011A.
- Assert abort during LOAD -> IDLE, status 0105 with status_valid pulse, all outputs low. Assert start together with abort in IDLE -> stays IDLE.
- Assert rst asynchronously mid-CFG (between edges) -> outputs reach reset values immediately. Pulse start after release -> clean BIST entry with retry_cnt=0.
